// File: rtl/mpu_pkg.sv
// Shared definitions for the CCSDS randomiser datapath (scrambler/descrambler pair).
// Holds codeblock geometry defaults, the byte-parallel LFSR step and the framing FSM states.
package mpu_pkg;

    localparam int unsigned MPU_BLOCK_LEN  = 255;
    localparam int unsigned MPU_PARITY_LEN = 32;
    localparam logic [7:0]  MPU_LFSR_SEED  = 8'hFF;

    typedef enum logic [0:0] {
        StHunt,
        StFrame
    } mpu_state_e;

    typedef struct packed {
        logic [7:0] state_next;
        logic [7:0] ks;
    } lfsr_step_t;

    // State bit 7 is the oldest sequence bit, so the keystream byte is the state itself
    // (msb-first); eight steps of a(n+8) = a(n+7)^a(n+5)^a(n+3)^a(n) yield the next byte.
    function automatic lfsr_step_t lfsr_step8(input logic [7:0] state);
        lfsr_step_t res;
        logic [7:0] s;
        s = state;
        for (int i = 0; i < 8; i++) begin
            s = {s[6:0], s[7] ^ s[4] ^ s[2] ^ s[0]};
        end
        res.state_next = s;
        res.ks         = state;
        return res;
    endfunction

endpackage

// File: rtl/ccsds_lfsr8.sv
// Seedable byte-step CCSDS LFSR. With load=1 the keystream byte is the seed and the state
// moves to the seed advanced by one byte; with advance=1 the stored state steps one byte.
module ccsds_lfsr8
    import mpu_pkg::*;
#(
    parameter logic [7:0] SEED = MPU_LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] ks
);

    logic [7:0] state_q;
    logic [7:0] state_d;
    logic [7:0] cur;
    lfsr_step_t step;

    always_comb begin
        cur     = load ? SEED : state_q;
        step    = lfsr_step8(cur);
        ks      = step.ks;
        state_d = (load || advance) ? step.state_next : state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/descrambler.sv
// Receive-side CCSDS descrambler: hunts for sop, XORs each codeblock with the restarted
// randomiser sequence and regenerates sop/last/is_parity from a byte position counter.
module descrambler
    import mpu_pkg::*;
#(
    parameter int unsigned BLOCK_LEN  = MPU_BLOCK_LEN,
    parameter int unsigned PARITY_LEN = MPU_PARITY_LEN,
    parameter logic [7:0]  LFSR_SEED  = MPU_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_axis_valid,
    output logic        s_axis_ready,
    input  logic [7:0]  s_axis_data,
    input  logic        s_axis_sop,
    output logic        m_axis_valid,
    input  logic        m_axis_ready,
    output logic [7:0]  m_axis_data,
    output logic        m_axis_sop,
    output logic        m_axis_last,
    output logic        m_axis_is_parity,
    output logic        frame_err,
    output logic [15:0] drop_cnt
);

    localparam logic [7:0] LAST_POS   = 8'(BLOCK_LEN - 1);
    localparam logic [7:0] PARITY_POS = 8'(BLOCK_LEN - PARITY_LEN);

    mpu_state_e  state_q, state_d;
    logic [7:0]  pos_q, pos_d;
    logic [15:0] drop_q, drop_d;
    logic        err_q, err_d;

    logic        m_valid_q, m_valid_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_sop_q, m_sop_d;
    logic        m_last_q, m_last_d;
    logic        m_par_q, m_par_d;

    logic        accept;
    logic        emit;
    logic [7:0]  out_pos;
    logic        lfsr_load;
    logic        lfsr_adv;
    logic [7:0]  ks;

    assign s_axis_ready = !m_valid_q || m_axis_ready;
    assign accept       = s_axis_valid && s_axis_ready;

    ccsds_lfsr8 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (lfsr_load),
        .advance(lfsr_adv),
        .ks     (ks)
    );

    // Framing: decide whether the accepted byte is emitted and where it sits in the block.
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        drop_d    = drop_q;
        err_d     = 1'b0;
        emit      = 1'b0;
        out_pos   = pos_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;

        if (accept) begin
            if (s_axis_sop) begin
                // A sop always restarts the block; mid-frame it also abandons the partial one.
                emit      = 1'b1;
                out_pos   = 8'd0;
                lfsr_load = 1'b1;
                err_d     = (state_q == StFrame) && (pos_q != 8'd0);
            end else begin
                unique case (state_q)
                    StFrame: begin
                        emit     = 1'b1;
                        lfsr_adv = 1'b1;
                    end
                    StHunt: begin
                        if (drop_q != 16'hFFFF) begin
                            drop_d = drop_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end

            if (emit) begin
                if (out_pos == LAST_POS) begin
                    state_d = StHunt;
                    pos_d   = 8'd0;
                end else begin
                    state_d = StFrame;
                    pos_d   = out_pos + 8'd1;
                end
            end
        end
    end

    // Output register: refill on emit, otherwise drain when downstream accepts.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_sop_d   = m_sop_q;
        m_last_d  = m_last_q;
        m_par_d   = m_par_q;

        if (emit) begin
            m_valid_d = 1'b1;
            m_data_d  = s_axis_data ^ ks;
            m_sop_d   = (out_pos == 8'd0);
            m_last_d  = (out_pos == LAST_POS);
            m_par_d   = (out_pos >= PARITY_POS);
        end else if (m_axis_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StHunt;
            pos_q     <= 8'd0;
            drop_q    <= 16'd0;
            err_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= 8'd0;
            m_sop_q   <= 1'b0;
            m_last_q  <= 1'b0;
            m_par_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_sop_q   <= m_sop_d;
            m_last_q  <= m_last_d;
            m_par_q   <= m_par_d;
        end
    end

    assign m_axis_valid     = m_valid_q;
    assign m_axis_data      = m_data_q;
    assign m_axis_sop       = m_sop_q;
    assign m_axis_last      = m_last_q;
    assign m_axis_is_parity = m_par_q;
    assign frame_err        = err_q;
    assign drop_cnt         = drop_q;

endmodule

// File: tb/tb_descrambler.sv
// Self-checking bench for descrambler: keystream table, hunting, loopback with gated
// handshakes, premature sop, downstream stall and asynchronous reset mid-frame.
module tb_descrambler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        s_sop = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_data;
    logic        m_sop;
    logic        m_last;
    logic        m_par;
    logic        frame_err;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    descrambler #(
        .BLOCK_LEN (255),
        .PARITY_LEN(32),
        .LFSR_SEED (8'hFF)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis_valid    (s_valid),
        .s_axis_ready    (s_ready),
        .s_axis_data     (s_data),
        .s_axis_sop      (s_sop),
        .m_axis_valid    (m_valid),
        .m_axis_ready    (m_ready),
        .m_axis_data     (m_data),
        .m_axis_sop      (m_sop),
        .m_axis_last     (m_last),
        .m_axis_is_parity(m_par),
        .frame_err       (frame_err),
        .drop_cnt        (drop_cnt)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       last;
        logic       par;
    } out_t;

    typedef struct {
        int         idx;
        logic [7:0] din;
        logic       chk_d;
        logic [7:0] exp_d;
        logic       exp_sop;
        logic       exp_last;
        logic       exp_par;
    } vec_t;

    out_t       cap[$];
    out_t       exp_q[$];
    logic [7:0] ks[0:254];
    logic [7:0] first_din;
    int         ferr_cnt = 0;
    int         ferr_at = -1;
    int         n_tests = 0;
    int         n_fail = 0;
    bit         rdy_rand = 1'b0;
    bit         rdy_hold = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) begin
                ferr_cnt++;
                ferr_at = cap.size();
            end
            if (m_valid && m_ready) cap.push_back({m_data, m_sop, m_last, m_par});
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_hold) m_ready = 1'b0;
        else if (rdy_rand) m_ready = ($urandom_range(0, 7) != 0);
        else m_ready = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic sop, input bit rnd_gap);
        logic acc;
        acc = 1'b0;
        if (rnd_gap && $urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_sop   = sop;
        for (int g = 0; g < 1000; g++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
        s_valid = 1'b0;
        s_sop   = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit rnd_data, input bit rnd_gap);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd_data ? 8'($urandom) : 8'h00;
            if (i == 0) first_din = d;
            exp_q.push_back({d ^ ks[i], i == 0, i == 254, i >= 223});
            send_byte(d, i == 0, rnd_gap);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int g = 0; g < 5000 && cap.size() < exp_q.size(); g++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check(name, 32'(cap.size()), 32'(exp_q.size()));
    endtask

    task automatic compare_stream(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            if (bad < 0 && cap[i] !== exp_q[i]) bad = i;
        end
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: byte %0d got {d,sop,last,par}=%0h, expected %0h",
                     name, bad, cap[bad], exp_q[bad]);
        end
        cap.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t       tbl[11];
        logic       a[0:2047];
        logic [11:0] snap;
        int         n_last;

        // Bit-serial reference of h(x)=x^8+x^7+x^5+x^3+1 from the all-ones seed.
        for (int n = 0; n < 8; n++) a[n] = 1'b1;
        for (int n = 0; n + 8 < 2048; n++) a[n + 8] = a[n + 7] ^ a[n + 5] ^ a[n + 3] ^ a[n];
        for (int i = 0; i < 255; i++) begin
            for (int b = 0; b < 8; b++) ks[i][7 - b] = a[8 * i + b];
        end

        tbl[0]  = '{0,   8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1,   8'h00, 1'b1, 8'h48, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{2,   8'h00, 1'b1, 8'h0E, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{3,   8'h00, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{4,   8'h00, 1'b1, 8'h9A, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{5,   8'h00, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{6,   8'h00, 1'b1, 8'h70, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{7,   8'h00, 1'b1, 8'hBC, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{222, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{223, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{254, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};

        // Reset values, observed while reset is still held.
        #1 rst_n = 1'b0;
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_sop", 32'(m_sop), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_par", 32'(m_par), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Hunting: ten sop=0 bytes are discarded.
        for (int i = 0; i < 10; i++) send_byte(8'(i + 8'h30), 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("hunt_drop_cnt", 32'(drop_cnt), 32'd10);
        check("hunt_no_output", 32'(cap.size()), 32'd0);

        // All-zero frame exposes the raw keystream.
        send_frame(255, 1'b0, 1'b0);
        wait_drain("zero_frame_count");
        foreach (tbl[k]) begin
            if (tbl[k].idx < cap.size()) begin
                if (tbl[k].chk_d)
                    check($sformatf("zero_data[%0d]", tbl[k].idx),
                          32'(cap[tbl[k].idx].d), 32'(tbl[k].exp_d ^ tbl[k].din));
                check($sformatf("zero_side[%0d]", tbl[k].idx),
                      {29'd0, cap[tbl[k].idx].sop, cap[tbl[k].idx].last, cap[tbl[k].idx].par},
                      {29'd0, tbl[k].exp_sop, tbl[k].exp_last, tbl[k].exp_par});
            end
        end
        compare_stream("zero_frame_stream");
        check("zero_drop_cnt_kept", 32'(drop_cnt), 32'd10);

        // Loopback of random blocks with gated valid and ready.
        rdy_rand = 1'b1;
        for (int f = 0; f < 4; f++) send_frame(255, 1'b1, 1'b1);
        wait_drain("loop_count");
        compare_stream("loop_stream");
        check("loop_no_frame_err", 32'(ferr_cnt), 32'd0);
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;

        // Premature sop at position 100.
        ferr_cnt = 0;
        send_frame(100, 1'b1, 1'b0);
        send_frame(255, 1'b1, 1'b0);
        wait_drain("early_sop_count");
        check("early_sop_err_pulses", 32'(ferr_cnt), 32'd1);
        check("early_sop_err_align", 32'(ferr_at), 32'd100);
        if (cap.size() > 100) begin
            check("early_sop_byte100_sop", 32'(cap[100].sop), 32'd1);
            check("early_sop_byte100_data", 32'(cap[100].d), 32'(first_din ^ 8'hFF));
        end
        n_last = 0;
        foreach (cap[k]) if (cap[k].last) n_last++;
        check("early_sop_last_count", 32'(n_last), 32'd1);
        compare_stream("early_sop_stream");

        // Downstream stall mid-frame.
        ferr_cnt = 0;
        fork
            send_frame(255, 1'b1, 1'b0);
            begin
                repeat (60) @(posedge clk);
                rdy_hold = 1'b1;
                repeat (2) @(negedge clk);
                snap = {m_valid, m_data, m_sop, m_last, m_par};
                check("stall_valid", 32'(m_valid), 32'd1);
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    check("stall_stable", 32'({m_valid, m_data, m_sop, m_last, m_par}),
                          32'(snap));
                    check("stall_s_ready", 32'(s_ready), 32'd0);
                end
                rdy_hold = 1'b0;
            end
        join
        wait_drain("stall_count");
        compare_stream("stall_stream");
        check("stall_no_frame_err", 32'(ferr_cnt), 32'd0);

        // Asynchronous reset at position 50.
        send_frame(50, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_m_valid", 32'(m_valid), 32'd0);
        check("arst_m_data", 32'(m_data), 32'd0);
        check("arst_side", 32'({m_sop, m_last, m_par, frame_err}), 32'd0);
        check("arst_drop_cnt", 32'(drop_cnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cap.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        send_frame(255, 1'b1, 1'b0);
        wait_drain("after_rst_count");
        compare_stream("after_rst_stream");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
